// File: rtl/bin2bcd_pkg.sv
// Shared constants and state encoding for the shift-add-3 BCD converter.
// Optional leading-zero blanking is enabled with BIN2BCD_BLANK_EN.
package bin2bcd_pkg;

  localparam int IN_W_DEF       = 27;
  localparam int DIGITS_DEF     = 8;
  localparam int MAX_VAL_DEF    = 99999999;
  localparam int BCD_ADJ_THRESH = 5;
  localparam int BCD_ADJ        = 3;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/bin2bcd_seq_adj.sv
// Combinational BCD nibble corrector: nibbles of 5 or more get +3
// so the following left shift carries correctly into the next digit.
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'(BCD_ADJ_THRESH)) ? din + 4'(BCD_ADJ) : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary to packed-BCD converter, one bit per clock.
// Define BIN2BCD_BLANK_EN to drive the leading-zero blank_mask output.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int IN_W    = IN_W_DEF,
  parameter int DIGITS  = DIGITS_DEF,
  parameter int MAX_VAL = MAX_VAL_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_W-1:0]     bin_in,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic                out_valid,
  output logic                ovf,
  output logic [DIGITS-1:0]   blank_mask
);

  localparam int CW = $clog2(IN_W);
  localparam logic [CW-1:0] LAST = CW'(IN_W - 1);
  localparam logic [IN_W-1:0] MAX_BIN = IN_W'(MAX_VAL);

  state_t              state;
  logic [4*DIGITS-1:0] bcd_work;
  logic [4*DIGITS-1:0] bcd_adj;
  logic [IN_W-1:0]     bin_work;
  logic [CW-1:0]       cnt;
  logic                ovf_pend;
  logic [DIGITS-1:0]   blank_nxt;
  logic                unused_msb;

  for (genvar k = 0; k < DIGITS; k++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (bcd_work[4*k +: 4]),
      .dout (bcd_adj[4*k +: 4])
    );
  end

  // Values are capped at MAX_VAL, so the top bit never carries out.
  assign unused_msb = bcd_adj[4*DIGITS-1];

`ifdef BIN2BCD_BLANK_EN
  logic hz;
  always_comb begin
    blank_nxt = '0;
    hz        = 1'b1;
    for (int k = DIGITS - 1; k > 0; k--) begin
      hz           = hz & (bcd_work[4*k +: 4] == 4'd0);
      blank_nxt[k] = hz;
    end
  end
`else
  assign blank_nxt = '0;
`endif

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bcd_work   <= '0;
      bin_work   <= '0;
      cnt        <= '0;
      ovf_pend   <= 1'b0;
      bcd_out    <= '0;
      ovf        <= 1'b0;
      blank_mask <= '0;
      out_valid  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            bcd_work <= '0;
            cnt      <= '0;
            state    <= SHIFT;
            if (bin_in > MAX_BIN) begin
              bin_work <= MAX_BIN;
              ovf_pend <= 1'b1;
            end else begin
              bin_work <= bin_in;
              ovf_pend <= 1'b0;
            end
          end
        end
        SHIFT: begin
          bcd_work <= {bcd_adj[4*DIGITS-2:0], bin_work[IN_W-1]};
          bin_work <= {bin_work[IN_W-2:0], 1'b0};
          cnt      <= cnt + 1'b1;
          if (cnt == LAST) state <= DONE;
        end
        DONE: begin
          bcd_out    <= bcd_work;
          ovf        <= ovf_pend;
          blank_mask <= blank_nxt;
          out_valid  <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
